// File: rtl/primary_ray_buffer.sv
// Indexed primary-ray buffer: captures the RPP rays of one pixel and streams them in index order.
// A write is visible 1 cycle later; out_rdy low holds the head ray and stalls the stream.
package primary_ray_pkg;
    typedef struct packed {
        logic [15:0] org_x;
        logic [15:0] org_y;
        logic [15:0] org_z;
        logic [15:0] dir_x;
        logic [15:0] dir_y;
        logic [15:0] dir_z;
    } ray_t;
endpackage

module primary_ray_buffer
    import primary_ray_pkg::*;
#(
    parameter int RPP       = 8,
    parameter int RPP_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [RPP_WIDTH-1:0] wr_ndx,
    input  ray_t                 wr_ray,
    output logic                 busy,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output ray_t                 out_ray,
    output logic [RPP_WIDTH-1:0] out_ndx,
    output logic                 out_last,
    output logic                 done,
    output logic                 err
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [RPP_WIDTH-1:0] LAST_NDX = RPP_WIDTH'(RPP - 1);

    state_t                 state;
    ray_t                   mem [RPP];
    logic [RPP-1:0]         vld;
    logic [RPP-1:0]         vld_nxt;
    logic [RPP_WIDTH-1:0]   rd_ptr;
    logic                   wr_ok;
    logic                   wr_bad;
    logic                   hs;
    logic                   fin;

    assign wr_ok    = wr_en && !vld[wr_ndx];
    assign wr_bad   = wr_en &&  vld[wr_ndx];
    assign out_vld  = vld[rd_ptr];
    assign out_ray  = mem[rd_ptr];
    assign out_ndx  = rd_ptr;
    assign out_last = out_vld && (rd_ptr == LAST_NDX);
    assign hs       = out_vld && out_rdy;
    assign fin      = hs && out_last;

    // A slot being read is still valid, so it can never also take a write this cycle.
    always_comb begin
        vld_nxt = vld;
        if (hs)
            vld_nxt[rd_ptr] = 1'b0;
        if (wr_ok)
            vld_nxt[wr_ndx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ndx] <= wr_ray;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            vld    <= '0;
            rd_ptr <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            vld  <= vld_nxt;
            done <= fin;
            if (hs)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_bad)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // A write landing with the final handshake starts the next pixel.
                    if (fin && !wr_ok) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_primary_ray_buffer.sv
// Bench for primary_ray_buffer: expected rays queued in index order, popped on each handshake.
module tb_primary_ray_buffer;
    import primary_ray_pkg::*;

    typedef struct packed {
        logic [2:0] ndx;
        ray_t       ray;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_ndx;
    ray_t       wr_ray;
    logic       busy;
    logic       out_vld;
    logic       out_rdy;
    ray_t       out_ray;
    logic [2:0] out_ndx;
    logic       out_last;
    logic       done;
    logic       err;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    ray_t px[8];

    primary_ray_buffer #(.RPP(8), .RPP_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ndx(wr_ndx), .wr_ray(wr_ray),
        .busy(busy), .out_vld(out_vld), .out_rdy(out_rdy), .out_ray(out_ray),
        .out_ndx(out_ndx), .out_last(out_last), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs are stable mid-cycle, so a negedge sample shows the handshake of the next posedge.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got ndx=%0d ray=%h, expected none", out_ndx, out_ray);
            end else begin
                e = sb.pop_front();
                if (out_ndx !== e.ndx || out_ray !== e.ray || out_last !== (e.ndx == 3'd7)) begin
                    errors++;
                    $display("FAIL stream_data: got ndx=%0d last=%b ray=%h, expected ndx=%0d ray=%h",
                             out_ndx, out_last, out_ray, e.ndx, e.ray);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ray_t make_ray();
        ray_t r;
        r = {$urandom, $urandom, $urandom};
        return r;
    endfunction

    task automatic new_pixel();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            px[i] = make_ray();
            e.ndx = 3'(i);
            e.ray = px[i];
            sb.push_back(e);
        end
    endtask

    task automatic write(input int ndx, input ray_t r);
        wr_en  = 1'b1;
        wr_ndx = 3'(ndx);
        wr_ray = r;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d rays left after %0d cycles, expected 0", name, sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wr_en = 1'b0; wr_ndx = '0; wr_ray = '0; out_rdy = 1'b0;
        do_reset();
        checks++;
        if ({busy, out_vld, out_last, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got busy,vld,last,done,err=%b, expected 00000",
                     {busy, out_vld, out_last, done, err});
        end
    endtask

    task automatic test_in_order();
        out_rdy = 1'b1;
        new_pixel();
        checks++;
        if (out_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL inorder_pre: got vld=%b busy=%b, expected 0 0", out_vld, busy);
        end
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_ndx = 3'(i); wr_ray = px[i];
            step();
            if (i == 0) begin
                checks++;
                if (out_vld !== 1'b1 || out_ndx !== 3'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL inorder_latency: got vld=%b ndx=%0d busy=%b, expected 1 0 1",
                             out_vld, out_ndx, busy);
                end
            end
        end
        wr_en = 1'b0;
        checks++;
        if (out_last !== 1'b1 || out_ndx !== 3'd7 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL inorder_last: got last=%b ndx=%0d done=%b busy=%b, expected 1 7 0 1",
                     out_last, out_ndx, done, busy);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL inorder_done: got done=%b busy=%b vld=%b, expected 1 0 0", done, busy, out_vld);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL inorder_done_pulse: got done=%b, expected 0", done);
        end
        wait_drain("inorder");
    endtask

    task automatic test_out_of_order();
        int order[8] = '{3, 1, 0, 2, 4, 5, 6, 7};
        out_rdy = 1'b1;
        new_pixel();
        for (int i = 0; i < 8; i++) begin
            write(order[i], px[order[i]]);
            if (i < 2) begin
                checks++;
                if (out_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL ooo_stall: got vld=%b after write %0d, expected 0", out_vld, order[i]);
                end
            end
        end
        wait_drain("ooo");
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ooo_done: got done=%b busy=%b, expected 1 0", done, busy);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        new_pixel();
        write(0, px[0]);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_vld !== 1'b1 || out_ndx !== 3'd0 || out_ray !== px[0]) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got vld=%b ndx=%0d ray=%h, expected 1 0 %h",
                         i, out_vld, out_ndx, out_ray, px[0]);
            end
            step();
        end
        out_rdy = 1'b1;
        for (int i = 1; i < 8; i++)
            write(i, px[i]);
        wait_drain("bp");
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: got done=%b, expected 1", done);
        end
        step();
    endtask

    task automatic test_overwrite();
        out_rdy = 1'b0;
        new_pixel();
        for (int i = 0; i < 3; i++)
            write(i, px[i]);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ovw_pre: got err=%b, expected 0", err);
        end
        write(2, ~px[2]);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL ovw_err: got err=%b, expected 1", err);
        end
        out_rdy = 1'b1;
        for (int i = 3; i < 8; i++)
            write(i, px[i]);
        wait_drain("ovw");
        step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL ovw_sticky: got err=%b, expected 1", err);
        end
    endtask

    task automatic test_back_to_back();
        ray_t a[8];
        do_reset();
        out_rdy = 1'b1;
        new_pixel();
        a = px;
        new_pixel();
        for (int i = 0; i < 8; i++)
            write(i, a[i]);
        // pixel A's slot 7 handshakes at this edge
        write(0, px[0]);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_vld !== 1'b1 || out_ndx !== 3'd0 || out_ray !== px[0]) begin
            errors++;
            $display("FAIL b2b_overlap: got done=%b busy=%b vld=%b ndx=%0d ray=%h, expected 1 1 1 0 %h",
                     done, busy, out_vld, out_ndx, out_ray, px[0]);
        end
        for (int i = 1; i < 8; i++)
            write(i, px[i]);
        wait_drain("b2b");
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got done=%b busy=%b err=%b, expected 1 0 0", done, busy, err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            px[i] = make_ray();
            e.ndx = 3'(i);
            e.ray = px[i];
            sb.push_back(e);
            write(i, px[i]);
        end
        write(3, ~px[3]);
        out_rdy = 1'b1;
        step();
        step();
        out_rdy = 1'b0;
        checks++;
        if (sb.size() != 2 || err !== 1'b1 || out_ndx !== 3'd2) begin
            errors++;
            $display("FAIL mid_pre: got left=%0d err=%b ndx=%0d, expected 2 1 2", sb.size(), err, out_ndx);
        end
        sb.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_vld !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got vld=%b busy=%b err=%b, expected 0 0 0", out_vld, busy, err);
        end
        out_rdy = 1'b1;
        new_pixel();
        for (int i = 0; i < 8; i++)
            write(i, px[i]);
        wait_drain("mid");
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_done: got done=%b busy=%b, expected 1 0", done, busy);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_backpressure();
        test_overwrite();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/primary_ray_buffer.md
Name: primary_ray_buffer

Overview:
- Receiving end of the primary-ray write interface driven by the primary-ray generation stage (wr_en / wr_ndx / wr_ray).
- Captures the RPP primary rays of one pixel into an indexed buffer.
- Streams them in index order (0..RPP-1) to the downstream trace stage over a valid/ready handshake.
- Reports when a pixel's full ray set has been drained, so the control path can launch the next pixel.

Parameters:
- RPP, 8, rays per pixel; must be a power of two, >= 2
- RPP_WIDTH, 3, log2(RPP); index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  wr_ray valid this cycle
- wr_ndx  in  RPP_WIDTH  buffer slot for wr_ray
- wr_ray  in  ray_t  primary ray from the generator
- busy  out  1  pixel in progress; upstream must not start a new pixel while high
- out_vld  out  1  out_ray/out_ndx valid
- out_rdy  in  1  downstream accepts the ray
- out_ray  out  ray_t  ray at the read pointer
- out_ndx  out  RPP_WIDTH  sample index of out_ray
- out_last  out  1  out_ndx == RPP-1, qualified by out_vld
- done  out  1  single-cycle pulse after the last ray of a pixel is accepted
- err  out  1  sticky protocol-error flag

Behaviour:
- Storage
  - RPP x ray_t array plus RPP valid bits (vld[i]).
  - rd_ptr: RPP_WIDTH bits.
  - State: IDLE or ACTIVE.
- Reset
  - busy=0, out_vld=0, out_last=0, done=0, err=0.
  - All vld[i]=0, rd_ptr=0, state=IDLE.
  - Array contents are not reset.
  - Reset mid-pixel discards all buffered rays, and the next cycle is IDLE.
- Write side
  - When wr_en=1 and vld[wr_ndx]=0: array[wr_ndx]<=wr_ray and vld[wr_ndx]<=1 at the clock edge.
  - The ray becomes readable the following cycle; there is no write-to-read bypass.
  - Writes may arrive in any index order and with any gaps.
  - Writes are accepted in both IDLE and ACTIVE.
- Write error
  - Condition: wr_en=1 and vld[wr_ndx]=1 (overwrite of an unread slot).
  - Action: the write is dropped, the stored ray and vld are unchanged, and err<=1.
  - err is cleared only by rst.
- State machine
  - IDLE -> ACTIVE on any accepted write.
  - ACTIVE -> IDLE on the cycle the RPP-1 entry handshakes (out_vld & out_rdy & out_last).
  - busy = (state==ACTIVE).
- Read side
  - out_vld = vld[rd_ptr]; out_ray = array[rd_ptr]; out_ndx = rd_ptr. These are combinational from registers.
  - Handshake occurs when out_vld & out_rdy. On handshake: vld[rd_ptr]<=0 and rd_ptr<=rd_ptr+1, wrapping from RPP-1 to 0.
  - Rays are emitted strictly in index order. An unfilled lower slot stalls the stream even if higher slots are filled.
  - While out_vld=1 and out_rdy=0, out_ray, out_ndx and out_vld hold stable.
  - out_rdy while out_vld=0 has no effect.
- Done
  - done is registered: it is 1 for exactly one cycle after the out_last handshake.
- Simultaneous events
  - A write to slot k while slot k is being read: k is still valid at that edge, so this is an overwrite error. The write is dropped, err=1, and the read completes.
  - A write to slot 0 in the same cycle as the final (RPP-1) handshake is accepted and begins the next pixel. State stays ACTIVE and busy stays 1.
  - done still pulses in this case.
- Throughput and latency
  - Throughput: 1 ray per cycle.
  - Latency: minimum 1 cycle from write to out_vld.

Test Plan:
- In-order fill, always-ready:
  - Stimulus: rst, then wr_ndx 0..7 on consecutive cycles with distinct rays, out_rdy=1.
  - Response: out_vld first rises 1 cycle after the first write; out_ndx 0..7 emitted on consecutive cycles with matching rays; out_last with ndx 7; done pulses one cycle later; busy falls with done.
- Out-of-order fill:
  - Stimulus: write ndx 3, 1, 0, 2, then 4..7.
  - Response: no out_vld until ndx 0 is written; output order is 0..7 regardless of write order.
- Backpressure:
  - Stimulus: out_rdy=0 for 5 cycles while slot 0 is valid.
  - Response: out_ray and out_ndx=0 hold stable; no slot is consumed; on out_rdy=1, streaming resumes without loss.
- Overwrite error:
  - Stimulus: write ndx 2 twice before it is read.
  - Response: err=1 from the next cycle and stays 1; the first ray is emitted at ndx 2.
- Pixel back-to-back:
  - Stimulus: write ndx 0 of pixel B on the cycle ndx 7 of pixel A handshakes.
  - Response: done pulses; busy stays 1; pixel B's ray 0 is emitted next with out_ndx=0.
- Reset mid-pixel:
  - Stimulus: assert rst after 4 of 8 rays are written and 2 are read.
  - Response: next cycle out_vld=0, busy=0, err=0; a new full pixel then streams 0..7 correctly.
